// File: rtl/ks_pkg.sv
// Shared keymap, FSM state type and sizing helper for keypad_scanner.
package ks_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        EMIT,
        HELD
    } ks_state_t;

    localparam logic [3:0] COL_IDLE = 4'b1110;

    // Row 3 holds the * and # positions, coded as E and F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic int ctr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ks_sync2.sv
// Two-flop synchronizer for the asynchronous keypad rows.
module ks_sync2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner with debounce and 8-digit entry register.
// Optional auto-repeat while a key is held: define KS_AUTOREPEAT_EN.
module keypad_scanner
    import ks_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 50000,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic        kS_clk_i,
    input  logic        kS_rst_i,
    input  logic [3:0]  kS_row_i,
    output logic [3:0]  kS_col_o,
    output logic [3:0]  kS_key_o,
    output logic        kS_key_valid_o,
    output logic [31:0] kS_value_o,
    output logic [3:0]  kS_digits_o
);

    localparam int CW = ctr_width(SCAN_DIV, DEB_CYCLES, REPEAT_DLY);
    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYCLES - 1);

    ks_state_t   state;
    logic [3:0]  row_s;
    logic [CW-1:0] cnt;
    logic [1:0]  col_idx;
    logic [1:0]  row_idx;
    logic [1:0]  low_row;
    logic [3:0]  pat;
    logic [3:0]  code;
    logic        one_low;

`ifdef KS_AUTOREPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);
    logic [CW-1:0] rep;
    logic          rep_first;
`endif

    ks_sync2 u_sync (
        .clk (kS_clk_i),
        .rst (kS_rst_i),
        .d   (kS_row_i),
        .q   (row_s)
    );

    // Two or more low rows in one column is a ghost and is never accepted.
    always_comb begin
        low_row = 2'd0;
        one_low = 1'b1;
        unique case (row_s)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    assign code = KEYMAP[row_idx][col_idx];

    always_ff @(posedge kS_clk_i) begin
        if (kS_rst_i) begin
            state          <= SCAN;
            cnt            <= '0;
            col_idx        <= 2'd0;
            row_idx        <= 2'd0;
            pat            <= 4'hF;
            kS_col_o       <= COL_IDLE;
            kS_key_o       <= 4'h0;
            kS_key_valid_o <= 1'b0;
            kS_value_o     <= 32'h0;
            kS_digits_o    <= 4'h0;
`ifdef KS_AUTOREPEAT_EN
            rep            <= '0;
            rep_first      <= 1'b1;
`endif
        end else begin
            kS_key_valid_o <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (one_low) begin
                            row_idx <= low_row;
                            pat     <= row_s;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx  <= col_idx + 2'd1;
                            kS_col_o <= {kS_col_o[2:0], kS_col_o[3]};
                        end
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                DEBOUNCE: begin
                    if (row_s != pat) begin
                        cnt      <= '0;
                        state    <= SCAN;
                        col_idx  <= col_idx + 2'd1;
                        kS_col_o <= {kS_col_o[2:0], kS_col_o[3]};
                    end else if (cnt == DEB_LAST) begin
                        cnt            <= '0;
                        state          <= EMIT;
                        kS_key_valid_o <= 1'b1;
                        kS_key_o       <= code;
                        kS_value_o     <= {kS_value_o[27:0], code};
                        if (kS_digits_o != 4'd8)
                            kS_digits_o <= kS_digits_o + 4'd1;
`ifdef KS_AUTOREPEAT_EN
                        rep       <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                EMIT: begin
                    state <= HELD;
`ifdef KS_AUTOREPEAT_EN
                    // The pulse cycle counts toward the next repeat interval.
                    if (row_s == pat) begin
                        rep <= ONE;
                    end else begin
                        rep       <= '0;
                        rep_first <= 1'b1;
                    end
`endif
                end
                HELD: begin
                    if (row_s == 4'hF) begin
                        if (cnt == DEB_LAST) begin
                            cnt      <= '0;
                            state    <= SCAN;
                            col_idx  <= col_idx + 2'd1;
                            kS_col_o <= {kS_col_o[2:0], kS_col_o[3]};
                        end else begin
                            cnt <= cnt + ONE;
                        end
                    end else begin
                        cnt <= '0;
                    end
`ifdef KS_AUTOREPEAT_EN
                    if (row_s == pat) begin
                        if (rep == (rep_first ? DLY_LAST : PER_LAST)) begin
                            rep            <= '0;
                            rep_first      <= 1'b0;
                            state          <= EMIT;
                            kS_key_valid_o <= 1'b1;
                            kS_key_o       <= code;
                            kS_value_o     <= {kS_value_o[27:0], code};
                            if (kS_digits_o != 4'd8)
                                kS_digits_o <= kS_digits_o + 4'd1;
                        end else begin
                            rep <= rep + ONE;
                        end
                    end else begin
                        rep       <= '0;
                        rep_first <= 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a column-shorting keypad model.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key;
    logic        key_valid;
    logic [31:0] value;
    logic [3:0]  digits;

    logic [15:0] keys = '0;
    logic        ovr_en = 1'b0;
    logic [3:0]  ovr_row = 4'hF;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int consec = 0;
    logic prev_valid = 1'b0;

    logic [3:0] colseq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV   (4),
        .DEB_CYCLES (8),
        .REPEAT_DLY (40),
        .REPEAT_PER (16)
    ) dut (
        .kS_clk_i       (clk),
        .kS_rst_i       (rst),
        .kS_row_i       (row),
        .kS_col_o       (col),
        .kS_key_o       (key),
        .kS_key_valid_o (key_valid),
        .kS_value_o     (value),
        .kS_digits_o    (digits)
    );

    // A pressed key shorts its row to its column whenever that column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
        if (ovr_en) row = ovr_row;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulses <= pulses + 1;
            if (prev_valid) consec <= consec + 1;
        end
        prev_valid <= key_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input int r, input int c, output int got);
        int p0;
        p0 = pulses;
        keys[r*4+c] = 1'b1;
        for (int i = 0; i < 40 && pulses == p0; i++) tick(1);
        tick(3);
        keys = '0;
        tick(20);
        got = pulses - p0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        total += 5;
        if (col !== 4'b1110) begin bad++; $display("FAIL rst_col got=%b exp=1110", col); end
        if (key !== 4'h0) begin bad++; $display("FAIL rst_key got=%h exp=0", key); end
        if (key_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", key_valid); end
        if (value !== 32'h0) begin bad++; $display("FAIL rst_value got=%h exp=0", value); end
        if (digits !== 4'h0) begin bad++; $display("FAIL rst_digits got=%0d exp=0", digits); end
        rst = 1'b0;
    endtask

    task automatic test_idle_scan;
        int p0;
        p0 = pulses;
        for (int i = 0; i < 100; i++) begin
            total++;
            if (col !== colseq[(i/4)%4]) begin
                bad++;
                $display("FAIL idle_col cyc=%0d got=%b exp=%b", i, col, colseq[(i/4)%4]);
            end
            tick(1);
        end
        total += 2;
        if (pulses != p0) begin bad++; $display("FAIL idle_pulses got=%0d exp=0", pulses - p0); end
        if (value !== 32'h0) begin bad++; $display("FAIL idle_value got=%h exp=0", value); end
    endtask

    task automatic test_single_press;
        int n;
        press_key(1, 2, n);
        total += 4;
        if (n != 1) begin bad++; $display("FAIL single_count got=%0d exp=1", n); end
        if (key !== 4'h6) begin bad++; $display("FAIL single_key got=%h exp=6", key); end
        if (value !== 32'h6) begin bad++; $display("FAIL single_value got=%h exp=6", value); end
        if (digits !== 4'd1) begin bad++; $display("FAIL single_digits got=%0d exp=1", digits); end
    endtask

    task automatic test_entry;
        int n;
        for (int i = 0; i < 9; i++) begin
            press_key(i / 3, i % 3, n);
            total++;
            if (n != 1 || key !== 4'(i + 1)) begin
                bad++;
                $display("FAIL entry_key idx=%0d got=%h n=%0d exp=%0d", i, key, n, i + 1);
            end
        end
        total += 2;
        if (value !== 32'h23456789) begin bad++; $display("FAIL entry_value got=%h exp=23456789", value); end
        if (digits !== 4'd8) begin bad++; $display("FAIL entry_digits got=%0d exp=8", digits); end
    endtask

    task automatic test_bounce;
        int p0;
        int n;
        p0 = pulses;
        ovr_en = 1'b1;
        ovr_row = 4'b1101;
        tick(5);
        ovr_row = 4'hF;
        tick(2);
        ovr_row = 4'b1101;
        tick(5);
        ovr_row = 4'hF;
        ovr_en = 1'b0;
        tick(20);
        total++;
        if (pulses != p0) begin bad++; $display("FAIL bounce_emit got=%0d exp=0", pulses - p0); end
        press_key(1, 1, n);
        total += 2;
        if (n != 1) begin bad++; $display("FAIL bounce_stable got=%0d exp=1", n); end
        if (key !== 4'h5) begin bad++; $display("FAIL bounce_key got=%h exp=5", key); end
    endtask

    task automatic test_ghost;
        int p0;
        logic [3:0] seen;
        p0 = pulses;
        seen = '0;
        keys[0] = 1'b1;
        keys[8] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 4; c++) if (col === colseq[c]) seen[c] = 1'b1;
            tick(1);
        end
        keys = '0;
        tick(20);
        total += 2;
        if (pulses != p0) begin bad++; $display("FAIL ghost_emit got=%0d exp=0", pulses - p0); end
        if (seen !== 4'hF) begin bad++; $display("FAIL ghost_scan got=%b exp=1111", seen); end
    endtask

    task automatic wait_col(input logic [3:0] want, input string tag);
        int i;
        for (i = 0; i < 40 && col !== want; i++) tick(1);
        if (col !== want) begin
            total++;
            bad++;
            $display("FAIL %s timeout got=%b exp=%b", tag, col, want);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        p0 = pulses;
        keys[1*4+2] = 1'b1;
        wait_col(4'b1101, "mid_wait1");
        wait_col(4'b1011, "mid_wait2");
        tick(5);
        rst = 1'b1;
        keys = '0;
        tick(1);
        total += 5;
        if (col !== 4'b1110) begin bad++; $display("FAIL mid_col got=%b exp=1110", col); end
        if (key !== 4'h0) begin bad++; $display("FAIL mid_key got=%h exp=0", key); end
        if (key_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", key_valid); end
        if (value !== 32'h0) begin bad++; $display("FAIL mid_value got=%h exp=0", value); end
        if (digits !== 4'h0) begin bad++; $display("FAIL mid_digits got=%0d exp=0", digits); end
        rst = 1'b0;
        tick(30);
        total++;
        if (pulses != p0) begin bad++; $display("FAIL mid_emit got=%0d exp=0", pulses - p0); end
    endtask

    task automatic test_hold;
        int p0;
        int n;
        p0 = pulses;
        keys[3] = 1'b1;
        tick(100);
        keys = '0;
        tick(20);
        n = pulses - p0;
        total += 3;
`ifdef KS_AUTOREPEAT_EN
        if (n < 3 || n > 5) begin bad++; $display("FAIL hold_repeat got=%0d exp=3..5", n); end
`else
        if (n != 1) begin bad++; $display("FAIL hold_single got=%0d exp=1", n); end
`endif
        if (key !== 4'hA) begin bad++; $display("FAIL hold_key got=%h exp=a", key); end
        if (value[3:0] !== 4'hA) begin bad++; $display("FAIL hold_value got=%h exp=xxxxxxxa", value); end
    endtask

    task automatic test_no_back_to_back;
        total++;
        if (consec != 0) begin bad++; $display("FAIL back_to_back got=%0d exp=0", consec); end
    endtask

    initial begin
        test_reset;
        test_idle_scan;
        test_single_press;
        test_entry;
        test_bounce;
        test_ghost;
        test_reset_mid;
        test_hold;
        test_no_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
